// File: rtl/sc_backgtype_sequencer_if.sv
// Control bundle between the game-event logic (master) and the background-type
// sequencer (slave).
interface sc_backgtype_sequencer_if #(
  parameter int BLINK_DATAWIDTH = 21
);
  logic                       SC_BackgSeq_start_InLow;
  logic                       SC_BackgSeq_levelwin_InLow;
  logic                       SC_BackgSeq_lose_InLow;
  logic                       SC_BackgSeq_clear_OutLow;
  logic                       SC_BackgSeq_load_OutLow;
  logic [3:0]                 SC_BackgSeq_transitioncounter_OutBUS;
  logic [BLINK_DATAWIDTH-1:0] SC_BackgSeq_blink_OutBUS;

  modport master (
    output SC_BackgSeq_start_InLow,
    output SC_BackgSeq_levelwin_InLow,
    output SC_BackgSeq_lose_InLow,
    input  SC_BackgSeq_clear_OutLow,
    input  SC_BackgSeq_load_OutLow,
    input  SC_BackgSeq_transitioncounter_OutBUS,
    input  SC_BackgSeq_blink_OutBUS
  );

  modport slave (
    input  SC_BackgSeq_start_InLow,
    input  SC_BackgSeq_levelwin_InLow,
    input  SC_BackgSeq_lose_InLow,
    output SC_BackgSeq_clear_OutLow,
    output SC_BackgSeq_load_OutLow,
    output SC_BackgSeq_transitioncounter_OutBUS,
    output SC_BackgSeq_blink_OutBUS
  );
endinterface

// File: rtl/sc_backgtype_sequencer.sv
// Game-flow controller for the background-type register: START -> transition
// -> levels -> WIN, or LOSE on a loss event. All outputs are registered.
module sc_backgtype_sequencer #(
  parameter int         BLINK_DATAWIDTH = 21,
  parameter int         TRANS_DATAWIDTH = 26,
  parameter int         TRANS_CYCLES    = 50000000,
  parameter logic [3:0] LAST_LEVEL      = 4'd8
) (
  input  logic                   SC_BackgSeq_CLOCK_50,
  input  logic                   SC_BackgSeq_RESET_InHigh,
  sc_backgtype_sequencer_if.slave seqBus
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    START = 3'd1,
    TRANS = 3'd2,
    LEVEL = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } stateType;

  localparam logic [TRANS_DATAWIDTH-1:0] TIMER_LAST = TRANS_DATAWIDTH'(TRANS_CYCLES - 1);

  stateType                   stateReg, stateNext;
  logic [3:0]                 counterReg, counterNext;
  logic                       loadReg, loadNext;
  logic                       clearReg, clearNext;
  logic [BLINK_DATAWIDTH-1:0] blinkReg, blinkNext;
  logic [TRANS_DATAWIDTH-1:0] timerReg, timerNext;

  logic startSample, startPrev;
  logic levelwinSample, levelwinPrev;
  logic startFall, levelwinFall;

  // Falling edge = previous registered sample high, current registered sample low.
  assign startFall    = startPrev & ~startSample;
  assign levelwinFall = levelwinPrev & ~levelwinSample;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    stateNext   = stateReg;
    counterNext = counterReg;
    loadNext    = 1'b1;
    clearNext   = 1'b1;
    blinkNext   = '0;
    timerNext   = '0;

    case (stateReg)
      INIT: begin
        stateNext   = START;
        counterNext = 4'd0;
        loadNext    = 1'b0;
      end

      START: begin
        if (startFall) begin
          stateNext   = TRANS;
          counterNext = 4'd1;
          loadNext    = 1'b0;
        end
      end

      TRANS: begin
        if (timerReg == TIMER_LAST) begin
          stateNext   = LEVEL;
          counterNext = counterReg + 4'd1;
          loadNext    = 1'b0;
        end else begin
          timerNext = timerReg + TRANS_DATAWIDTH'(1);
          blinkNext = blinkReg + BLINK_DATAWIDTH'(1);
        end
      end

      LEVEL: begin
        // A loss outranks a simultaneous goal.
        if (!seqBus.SC_BackgSeq_lose_InLow) begin
          stateNext = LOSE;
          clearNext = 1'b0;
        end else if (levelwinFall) begin
          counterNext = counterReg + 4'd1;
          loadNext    = 1'b0;
          stateNext   = (counterReg == LAST_LEVEL) ? WIN : TRANS;
        end
      end

      WIN, LOSE: begin
        if (startFall) begin
          stateNext = INIT;
        end else begin
          blinkNext = blinkReg + BLINK_DATAWIDTH'(1);
        end
      end

      default: stateNext = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge SC_BackgSeq_CLOCK_50) begin
    if (SC_BackgSeq_RESET_InHigh) begin
      stateReg       <= INIT;
      counterReg     <= 4'd0;
      loadReg        <= 1'b1;
      clearReg       <= 1'b1;
      blinkReg       <= '0;
      timerReg       <= '0;
      startSample    <= 1'b1;
      startPrev      <= 1'b1;
      levelwinSample <= 1'b1;
      levelwinPrev   <= 1'b1;
    end else begin
      stateReg       <= stateNext;
      counterReg     <= counterNext;
      loadReg        <= loadNext;
      clearReg       <= clearNext;
      blinkReg       <= blinkNext;
      timerReg       <= timerNext;
      startSample    <= seqBus.SC_BackgSeq_start_InLow;
      startPrev      <= startSample;
      levelwinSample <= seqBus.SC_BackgSeq_levelwin_InLow;
      levelwinPrev   <= levelwinSample;
    end
  end

  assign seqBus.SC_BackgSeq_clear_OutLow             = clearReg;
  assign seqBus.SC_BackgSeq_load_OutLow              = loadReg;
  assign seqBus.SC_BackgSeq_transitioncounter_OutBUS = counterReg;
  assign seqBus.SC_BackgSeq_blink_OutBUS             = blinkReg;

endmodule

// File: tb/tb_sc_backgtype_sequencer.sv
// Self-checking bench: directed game-flow scenarios followed by random button
// traffic, all compared against a screen-index based reference model.
module tb_sc_backgtype_sequencer;

  localparam int BW = 21;
  localparam int TW = 26;
  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  sc_backgtype_sequencer_if #(.BLINK_DATAWIDTH(BW)) seqBus ();

  sc_backgtype_sequencer #(
    .BLINK_DATAWIDTH(BW),
    .TRANS_DATAWIDTH(TW),
    .TRANS_CYCLES   (TC),
    .LAST_LEVEL     (4'd8)
  ) dut (
    .SC_BackgSeq_CLOCK_50    (clk),
    .SC_BackgSeq_RESET_InHigh(rst),
    .seqBus                  (seqBus)
  );

  always #5 clk = ~clk;

  // Reference model: the screen index itself tracks game progress
  // (0 start, odd transition, even level, 9 win), plus a lost flag and a
  // pending-restart flag; button edges come from a history of sampled values.
  int mScreen;
  bit mRestart;
  bit mLost;
  bit mLoad;
  bit mClear;
  int mBlink;
  int mTimer;
  bit startHist[$];
  bit lwHist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input bit s, input bit lw, input bit lo, input bit r);
    bit sFall, lwFall;
    if (r) begin
      mScreen = 0; mRestart = 1; mLost = 0;
      mLoad = 1; mClear = 1; mBlink = 0; mTimer = 0;
      startHist = '{1'b1, 1'b1};
      lwHist    = '{1'b1, 1'b1};
      return;
    end
    sFall  = startHist[$-1] && !startHist[$];
    lwFall = lwHist[$-1] && !lwHist[$];
    mLoad  = 1;
    mClear = 1;
    if (mRestart) begin
      mRestart = 0; mScreen = 0; mLoad = 0; mBlink = 0;
    end else if (mLost || mScreen == 9) begin
      if (sFall) begin
        mRestart = 1; mLost = 0; mBlink = 0;
      end else begin
        mBlink = (mBlink + 1) % (1 << BW);
      end
    end else if (mScreen == 0) begin
      mBlink = 0;
      if (sFall) begin
        mScreen = 1; mLoad = 0;
      end
    end else if (mScreen % 2 == 1) begin
      if (mTimer == TC - 1) begin
        mTimer = 0; mBlink = 0; mScreen++; mLoad = 0;
      end else begin
        mTimer++; mBlink = (mBlink + 1) % (1 << BW);
      end
    end else begin
      mBlink = 0;
      if (!lo) begin
        mClear = 0; mLost = 1;
      end else if (lwFall) begin
        mScreen++; mLoad = 0;
      end
    end
    startHist.push_back(s);
    lwHist.push_back(lw);
    if (startHist.size() > 4) void'(startHist.pop_front());
    if (lwHist.size() > 4) void'(lwHist.pop_front());
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
  task automatic step(input bit s, input bit lw, input bit lo, input bit r = 1'b0);
    @(negedge clk);
    seqBus.SC_BackgSeq_start_InLow    = s;
    seqBus.SC_BackgSeq_levelwin_InLow = lw;
    seqBus.SC_BackgSeq_lose_InLow     = lo;
    rst                               = r;
    @(posedge clk);
    modelStep(s, lw, lo, r);
    #1;
    check("load", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'(mLoad));
    check("clear", 32'(seqBus.SC_BackgSeq_clear_OutLow), 32'(mClear));
    check("counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'(mScreen));
    check("blink", 32'(seqBus.SC_BackgSeq_blink_OutBUS), 32'(mBlink));
    check("load_clear_excl",
          32'(seqBus.SC_BackgSeq_load_OutLow | seqBus.SC_BackgSeq_clear_OutLow), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    seqBus.SC_BackgSeq_start_InLow    = 1'b1;
    seqBus.SC_BackgSeq_levelwin_InLow = 1'b1;
    seqBus.SC_BackgSeq_lose_InLow     = 1'b1;

    // Reset and the single INIT load pulse.
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    check("rst_load", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd1);
    check("rst_clear", 32'(seqBus.SC_BackgSeq_clear_OutLow), 32'd1);
    check("rst_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd0);
    step(1, 1, 1);
    check("init_load_low", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd0);
    step(1, 1, 1);
    check("init_load_one_cycle", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd1);
    idle(4);
    check("start_blink_zero", 32'(seqBus.SC_BackgSeq_blink_OutBUS), 32'd0);

    // Start edge -> TRANS two cycles later, blink 0..3, LEVEL 2 after TC cycles.
    step(0, 1, 1);
    check("start_not_yet", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd0);
    step(1, 1, 1);
    check("trans1_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd1);
    check("trans1_load", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd0);
    idle(3);
    check("trans1_blink3", 32'(seqBus.SC_BackgSeq_blink_OutBUS), 32'd3);
    idle(1);
    check("level2_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd2);
    check("level2_load", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd0);

    // Four goals: 2->3->4->5->6->7->8->9 (WIN from 8).
    for (int lvl = 0; lvl < 4; lvl++) begin
      idle($urandom_range(1, 3));
      step(1, 0, 1);
      step(1, 1, 1);
      check("goal_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'(3 + 2 * lvl));
      if (lvl < 3) begin
        idle(TC);
        check("next_level", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'(4 + 2 * lvl));
      end
    end
    idle(5);
    check("win_blink", 32'(seqBus.SC_BackgSeq_blink_OutBUS), 32'd5);

    // Restart from WIN holding start low: exactly one pass through INIT.
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    check("restart_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd0);
    check("restart_load", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 1);
    check("held_start_no_retrigger", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd0);

    // Reach level 4, then lose and goal together.
    step(1, 1, 1);
    idle(2);
    step(0, 1, 1);
    step(1, 1, 1);
    idle(TC);
    step(1, 0, 1);
    step(1, 1, 1);
    idle(TC);
    check("level4_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd4);
    step(1, 0, 1);
    step(1, 0, 0);
    check("lose_clear", 32'(seqBus.SC_BackgSeq_clear_OutLow), 32'd0);
    check("lose_no_load", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd1);
    check("lose_counter_held", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd4);
    step(1, 1, 1);
    check("lose_clear_one_cycle", 32'(seqBus.SC_BackgSeq_clear_OutLow), 32'd1);
    idle(3);
    step(0, 1, 1);
    step(1, 1, 1);
    step(1, 1, 1);
    check("lose_restart_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd0);

    // Reset in the middle of a transition screen (timer = 2).
    idle(1);
    step(0, 1, 1);
    step(1, 1, 1);
    idle(2);
    check("pre_reset_blink", 32'(seqBus.SC_BackgSeq_blink_OutBUS), 32'd2);
    step(1, 1, 1, 1);
    check("midrst_counter", 32'(seqBus.SC_BackgSeq_transitioncounter_OutBUS), 32'd0);
    check("midrst_blink", 32'(seqBus.SC_BackgSeq_blink_OutBUS), 32'd0);
    check("midrst_load", 32'(seqBus.SC_BackgSeq_load_OutLow), 32'd1);
    check("midrst_clear", 32'(seqBus.SC_BackgSeq_clear_OutLow), 32'd1);
    step(1, 1, 1);

    // Random button traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 7) != 0),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 39) != 0),
           bit'($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
